// File: rtl/mcu_pkg.sv
// Shared types and encodings for the multicycle ARM-subset controller.
// MCU_MUL_STALL_EN adds the MULWAIT state used by the multi-cycle multiply stall.
package mcu_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9
`ifdef MCU_MUL_STALL_EN
    , S_MULWAIT = 4'd10
`endif
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_MUL = 3'b010;
  localparam logic [2:0] ALU_ACM = 3'b011;
  localparam logic [2:0] ALU_AND = 3'b100;
  localparam logic [2:0] ALU_ORR = 3'b101;
  localparam logic [2:0] ALU_PRM = 3'b110;

  localparam logic [3:0] CMD_ADD = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0001;
  localparam logic [3:0] CMD_MUL = 4'b0010;
  localparam logic [3:0] CMD_CMP = 4'b0100;
  localparam logic [3:0] CMD_AND = 4'b1000;
  localparam logic [3:0] CMD_ORR = 4'b1001;
  localparam logic [3:0] CMD_PRM = 4'b1010;
  localparam logic [3:0] CMD_ACM = 4'b1011;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_READDATA  = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCB_RM   = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

endpackage

// File: rtl/mcu_alu_decoder.sv
// Combinational decode of the data-processing command/S bits into ALU
// operation, flag-write enables and the CMP no-write indication.
module mcu_alu_decoder
  import mcu_pkg::*;
(
  input  logic [1:0] op,
  input  logic [4:0] cmd_s,
  output logic [2:0] alu_op,
  output logic [1:0] flag_w,
  output logic       no_write
);

  logic arith;

  always_comb begin
    alu_op = ALU_ADD;
    arith  = 1'b0;
    case (cmd_s[4:1])
      CMD_ADD: begin alu_op = ALU_ADD; arith = 1'b1; end
      CMD_SUB: begin alu_op = ALU_SUB; arith = 1'b1; end
      CMD_CMP: begin alu_op = ALU_SUB; arith = 1'b1; end
      CMD_MUL: alu_op = ALU_MUL;
      CMD_AND: alu_op = ALU_AND;
      CMD_ORR: alu_op = ALU_ORR;
      CMD_PRM: alu_op = ALU_PRM;
      CMD_ACM: alu_op = ALU_ACM;
      default: alu_op = ALU_ADD;
    endcase
  end

  // C/V only make sense for the adder-based operations
  assign flag_w   = {cmd_s[0], cmd_s[0] & arith};
  assign no_write = (op == OP_DP) && (cmd_s[4:1] == CMD_CMP);

endmodule

// File: rtl/multicycle_control_unit.sv
// Moore FSM sequencing ARM-subset instructions over a shared ALU/memory.
// Define MCU_MUL_STALL_EN to stall MUL for MUL_LATENCY execute cycles.
module multicycle_control_unit
  import mcu_pkg::*;
#(
  parameter int ALU_CTRL_W  = 3,
  parameter int MUL_LATENCY = 4
)
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            Op,
  input  logic [5:0]            Funct,
  input  logic [3:0]            Rd,
  input  logic                  CondEx,
  input  logic                  MemReady,
  output logic                  PCWrite,
  output logic                  AdrSrc,
  output logic                  IRWrite,
  output logic                  MemW,
  output logic                  RegW,
  output logic [1:0]            ResultSrc,
  output logic                  ALUSrcA,
  output logic [1:0]            ALUSrcB,
  output logic [1:0]            ImmSrc,
  output logic [1:0]            RegSrc,
  output logic [ALU_CTRL_W-1:0] ALUControl,
  output logic [1:0]            FlagW,
  output logic                  NoWrite,
  output logic                  InstrDone,
  output logic                  Illegal,
  output state_t                fsm_state
);

  if (MUL_LATENCY < 1 || MUL_LATENCY > 15) begin : g_bad_latency
    $error("MUL_LATENCY must be in 1..15");
  end

  state_t     state;
  logic [2:0] dec_alu;
  logic [1:0] dec_flag_w;
  logic       dec_no_write;
  logic       rd_pc;
  logic       pc_write, ir_write, mem_w, reg_w, instr_done, illegal;
  logic [1:0] flag_w;
  logic [2:0] alu_sel;

  mcu_alu_decoder u_alu_dec (
    .op       (Op),
    .cmd_s    (Funct[4:0]),
    .alu_op   (dec_alu),
    .flag_w   (dec_flag_w),
    .no_write (dec_no_write)
  );

  assign rd_pc = (Rd == 4'd15);

`ifdef MCU_MUL_STALL_EN
  logic [3:0] mul_cnt;
  logic       mul_stall;
  assign mul_stall = (dec_alu == ALU_MUL) && (MUL_LATENCY > 1);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_FETCH;
`ifdef MCU_MUL_STALL_EN
      mul_cnt <= '0;
`endif
    end else begin
      case (state)
        S_FETCH:  if (MemReady) state <= S_DECODE;
        S_DECODE: begin
          case (Op)
            OP_MEM:  state <= S_MEMADR;
            OP_DP:   state <= Funct[5] ? S_EXECI : S_EXECR;
            OP_BR:   state <= S_BRANCH;
            default: state <= S_FETCH;
          endcase
        end
        S_MEMADR:   state <= Funct[0] ? S_MEMREAD : S_MEMWRITE;
        S_MEMREAD:  if (MemReady) state <= S_MEMWB;
        S_MEMWRITE: if (MemReady) state <= S_FETCH;
        S_EXECR, S_EXECI: begin
`ifdef MCU_MUL_STALL_EN
          if (mul_stall) begin
            state   <= S_MULWAIT;
            mul_cnt <= 4'(MUL_LATENCY - 1);
          end else begin
            state <= S_ALUWB;
          end
`else
          state <= S_ALUWB;
`endif
        end
`ifdef MCU_MUL_STALL_EN
        // count of 1 marks the final wait cycle; it reaches 0 on leaving
        S_MULWAIT: begin
          mul_cnt <= mul_cnt - 4'd1;
          if (mul_cnt == 4'd1) state <= S_ALUWB;
        end
`endif
        default: state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    mem_w      = 1'b0;
    reg_w      = 1'b0;
    instr_done = 1'b0;
    illegal    = 1'b0;
    flag_w     = 2'b00;
    alu_sel    = ALU_ADD;
    AdrSrc     = 1'b0;
    ResultSrc  = RES_ALUOUT;
    ALUSrcA    = 1'b0;
    ALUSrcB    = SRCB_RM;
    case (state)
      S_FETCH: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        ir_write  = MemReady;
        pc_write  = MemReady;
      end
      S_DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        illegal    = (Op == 2'b11);
        instr_done = (Op == 2'b11);
      end
      S_MEMADR:  ALUSrcB = SRCB_IMM;
      S_MEMREAD: AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc  = RES_READDATA;
        reg_w      = CondEx;
        pc_write   = CondEx & rd_pc;
        instr_done = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc     = 1'b1;
        mem_w      = CondEx;
        instr_done = MemReady;
      end
      S_EXECR, S_EXECI: begin
        ALUSrcB = (state == S_EXECI) ? SRCB_IMM : SRCB_RM;
        alu_sel = dec_alu;
`ifdef MCU_MUL_STALL_EN
        flag_w  = mul_stall ? 2'b00 : dec_flag_w;
`else
        flag_w  = dec_flag_w;
`endif
      end
`ifdef MCU_MUL_STALL_EN
      S_MULWAIT: begin
        alu_sel = ALU_MUL;
        flag_w  = (mul_cnt == 4'd1) ? dec_flag_w : 2'b00;
      end
`endif
      S_ALUWB: begin
        ResultSrc  = RES_ALUOUT;
        reg_w      = CondEx & ~dec_no_write;
        pc_write   = CondEx & ~dec_no_write & rd_pc;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcB    = SRCB_IMM;
        ResultSrc  = RES_ALURESULT;
        pc_write   = CondEx;
        instr_done = 1'b1;
      end
      default: ;
    endcase
  end

  // reset masks every strobe even though the mux selects track FETCH
  assign PCWrite    = pc_write & ~reset;
  assign IRWrite    = ir_write & ~reset;
  assign MemW       = mem_w & ~reset;
  assign RegW       = reg_w & ~reset;
  assign FlagW      = flag_w & {2{~reset}};
  assign InstrDone  = instr_done & ~reset;
  assign Illegal    = illegal & ~reset;
  assign ALUControl = ALU_CTRL_W'(alu_sel);
  assign NoWrite    = dec_no_write;
  assign ImmSrc     = Op;
  assign RegSrc     = {(Op == OP_MEM) & ~Funct[0], (Op == OP_BR)};
  assign fsm_state  = state;

endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Multi-cycle successor to the single-cycle ARM-subset control decoder. A Moore FSM sequences each instruction over several cycles on a shared ALU and a unified instruction/data memory, and waits on a memory ready handshake. It sits in the datapath's controller next to the condition/flag logic and drives all mux selects and write strobes. It optionally stalls multi-cycle MUL operations.

## Interface
Parameters:
- ALU_CTRL_W, 3: width of ALUControl.
- MUL_LATENCY, 4: execute cycles for MUL; legal range 1..15. Used only with the macro defined.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- Op  in  2  instruction class (instr[27:26]); sampled from the instruction register.
- Funct  in  6  instr[25:20] (I, opcode, S).
- Rd  in  4  destination register.
- CondEx  in  1  condition passed; from condition logic, valid from DECODE on.
- MemReady  in  1  memory completes the current access this cycle.
- PCWrite  out  1  PC load strobe.
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALU result register.
- IRWrite  out  1  instruction register load.
- MemW  out  1  memory write.
- RegW  out  1  register file write.
- ResultSrc  out  2  result select: 00 = ALUOut, 01 = ReadData, 10 = ALUResult.
- ALUSrcA  out  1  ALU A select: 0 = Rn, 1 = PC.
- ALUSrcB  out  2  ALU B select: 00 = Rm, 01 = ExtImm, 10 = constant 4.
- ImmSrc  out  2  extend type: 00 = DP, 01 = LDR/STR, 10 = branch.
- RegSrc  out  2  register address selects (same meaning as the single-cycle unit).
- ALUControl  out  ALU_CTRL_W  ALU operation.
- FlagW  out  2  flag update enables: [1] = N/Z, [0] = C/V.
- NoWrite  out  1  current instruction is a CMP.
- InstrDone  out  1  one-cycle pulse on the last cycle of every instruction.
- Illegal  out  1  one-cycle pulse in DECODE when Op = 11.

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, MULWAIT (macro only), ALUWB, BRANCH.
- All outputs not listed for a state are 0. ALUControl defaults to ADD.
- FETCH: AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, IRWrite=PCWrite=MemReady. Goes to DECODE when MemReady = 1, otherwise stays.
- DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10 (PC+8 precompute). Next state:
  - Op=01 → MEMADR.
  - Op=00 with Funct[5]=1 → EXECI; Op=00 with Funct[5]=0 → EXECR.
  - Op=10 → BRANCH.
  - Op=11 → FETCH, with Illegal and InstrDone pulsed.
- MEMADR: ALUSrcB=01, ADD. Funct[0]=1 → MEMREAD, else → MEMWRITE.
- MEMREAD: AdrSrc=1. Goes to MEMWB when MemReady = 1.
- MEMWB: ResultSrc=01, RegW=CondEx, PCWrite=CondEx & (Rd==15), InstrDone. Then → FETCH.
- MEMWRITE: AdrSrc=1, MemW=CondEx, held until MemReady. Then → FETCH with InstrDone.
  - If CondEx = 0, MemW stays 0 and the FSM still waits for MemReady.
- EXECR / EXECI:
  - ALUSrcB = 00 in EXECR, 01 in EXECI.
  - ALUControl from Funct[4:1]: 0000 ADD=000, 0001 SUB=001, 0010 MUL=010, 1000 AND=100, 1001 ORR=101, 1010 PRM=110, 1011 ACM=011, 0100 CMP=SUB. Any other code → ADD.
  - FlagW[1]=Funct[0]; FlagW[0]=Funct[0] & (ADD|SUB|CMP). Both are asserted for exactly one cycle.
  - Next state → ALUWB.
- ALUWB: ResultSrc=00, RegW=CondEx & ~NoWrite, PCWrite=CondEx & ~NoWrite & (Rd==15), InstrDone. Then → FETCH.
- BRANCH: ALUSrcB=01, ResultSrc=10, PCWrite=CondEx, InstrDone. Then → FETCH.
- NoWrite = (Op==00) & (Funct[4:1]==0100), valid in every state.
- ImmSrc = Op; RegSrc = {Op==01 & ~Funct[0], Op==10}. Both are combinational from Op/Funct.

## Timing
- Reset is asynchronous: state → FETCH immediately. While reset is high, PCWrite, IRWrite, MemW, RegW, FlagW, InstrDone and Illegal are forced to 0.
- Reset asserted mid-instruction aborts it with no further strobes.
- Cycle counts with MemReady tied high: LDR 5, STR 4, DP 4, B 3. Each MemReady low cycle adds one.
- All strobes are Moore decodes of the registered state plus the current-cycle inputs listed; there is no output register stage.

## Configuration
- MCU_MUL_STALL_EN defined:
  - EXECR/EXECI with MUL go to MULWAIT.
  - A counter loads MUL_LATENCY-1 and counts down; ALUControl holds MUL; → ALUWB at count 0.
  - FlagW is asserted only in the last MULWAIT cycle.
  - MUL_LATENCY=1 skips MULWAIT.
- Undefined: MULWAIT and the counter are absent, and MUL takes the normal DP path.

## Structure
- Package mcu_pkg holds:
  - state enum typedef;
  - ALU operation localparams (ADD…ACM);
  - Funct opcode constants;
  - ResultSrc/ALUSrcB encodings.
- Sub-module mcu_alu_decoder (combinational Funct → ALUControl/FlagW/NoWrite) is natural; the FSM instantiates it.

## Test plan
- MemReady=1, ADD r1 register, S=1, CondEx=1 → FETCH,DECODE,EXECR,ALUWB. ALUControl=000 and FlagW=11 in EXECR; RegW=1 in ALUWB; InstrDone on cycle 4.
- LDR with MemReady low for 2 cycles in MEMREAD → 7-cycle instruction. RegW=1 only in MEMWB, ResultSrc=01.
- STR with CondEx=0 → MemW never asserted; returns to FETCH after MemReady.
- CMP immediate (Funct=101001) → FlagW=11, NoWrite=1, RegW=0 in ALUWB.
- Op=11 → Illegal pulse in DECODE, back to FETCH. Reset asserted during MEMWRITE → MemW drops asynchronously and state=FETCH.
- With MCU_MUL_STALL_EN, MUL_LATENCY=4 → 3 MULWAIT cycles; FlagW only in the last one; total 7 cycles.
